truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

- Sequential stimulus-and-capture stage wrapped around a 4-input combinational function block.
- Drives outputs A, B, C, D through all 16 input combinations in ascending order, waits a programmable settle time per vector, and samples the function output F.
- Assembles the captured values into a 16-bit truth table.
- Replaces hand-written exhaustive stimulus for on-chip self-check of small logic functions.

## Interface

Parameters:
- SETTLE_CYCLES, default 1: cycles each vector is held before F is sampled. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep. Sampled on the clk rising edge.
- A  output  1  function input, MSB of the vector index.
- B  output  1  function input.
- C  output  1  function input.
- D  output  1  function input, LSB of the vector index.
- F  input  1  function output under test.
- expected  input  16  golden truth table. Bit i corresponds to vector i = {A,B,C,D}.
- table_out  output  16  captured truth table. Bit i = F sampled while vector i was driven.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start.
- match  output  1  comparison result (see Configuration).

## Operation

- Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
- Reset values: A = B = C = D = 0, table_out = 16'h0000, busy = 0, done = 0, match = 0, idx = 0, settle counter = 0, state IDLE.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, or DONE, with start = 1: go to DRIVE.
  - Set idx = 0, clear table_out to 0, set busy = 1, clear done and match.
  - Load the settle counter with SETTLE_CYCLES - 1.
- DRIVE: {A,B,C,D} = idx, registered.
  - Counter nonzero: decrement it.
  - Counter zero: go to SAMPLE.
- SAMPLE: on the edge leaving this state, table_out[idx] <= F.
  - idx != 15: idx <= idx + 1, reload the counter, go to DRIVE.
  - idx == 15: go to DONE; on the same edge busy <= 0 and done <= 1.
- DONE: hold table_out, done, match and {A,B,C,D} = 4'b1111 until start or rst.
- start while busy = 1 is ignored. It is not queued.
- idx is 4 bits. The sweep ends at 15; idx never wraps during a sweep.
- rst asserted mid-sweep: all registers return to their reset values immediately. A partial table is discarded.

## Timing

- Each vector occupies SETTLE_CYCLES + 1 cycles: SETTLE_CYCLES in DRIVE, then 1 in SAMPLE.
- F is therefore stable for at least SETTLE_CYCLES full cycles before it is captured.
- Latency: done rises 16 × (SETTLE_CYCLES + 1) cycles after the edge that accepts start. This is 32 cycles at the default.
- busy rises on the accepting edge and falls on the same edge that done rises.
- start and completion on the same edge cannot occur: start is accepted only in IDLE or DONE.
- A, B, C, D change only on clk edges. They are glitch-free registered outputs.

## Configuration

- Macro: TRUTH_TABLE_COMPARE_EN.
- Defined:
  - On the edge entering DONE, match <= (final table_out == expected).
  - The final table_out includes the bit captured on that edge.
  - expected is sampled on that same edge only.
  - match is cleared when start is accepted.
- Undefined:
  - No comparator is built.
  - match is tied to 0.
  - expected is present but unused.

## Test plan

- Reset, then start pulse with the bench model F = A & B, SETTLE_CYCLES = 1 -> busy high for 32 cycles; then done = 1, busy = 0, table_out = 16'hF000.
- F = A ^ B ^ C ^ D, expected = 16'h6996, TRUTH_TABLE_COMPARE_EN defined -> table_out = 16'h6996, match = 1.
- Same sweep with expected = 16'h6997 -> match = 0. With the macro undefined -> match = 0 in both cases.
- start pulsed again at vector 5 mid-sweep -> ignored; done still arrives 32 cycles after the first accepted start.
- rst asserted at vector 9, then released -> all outputs 0 and state IDLE. A fresh start yields a complete, correct table.
- SETTLE_CYCLES = 3, F = D -> each vector held 4 cycles, done after 64 cycles, table_out = 16'hAAAA. A restart from DONE clears done and table_out on the accepting edge.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between the truth-table sweeper and the function block / host around it.
`timescale 1ns/1ps
interface truth_table_sweeper_if;
    logic        start;
    logic        A;
    logic        B;
    logic        C;
    logic        D;
    logic        F;
    logic [15:0] expected;
    logic [15:0] table_out;
    logic        busy;
    logic        done;
    logic        match;

    modport master (
        output start, F, expected,
        input  A, B, C, D, table_out, busy, done, match
    );

    modport slave (
        input  start, F, expected,
        output A, B, C, D, table_out, busy, done, match
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives all 16 {A,B,C,D} vectors, settles, samples F and assembles a truth table.
// Optional golden-table comparator: define TRUTH_TABLE_COMPARE_EN.
`timescale 1ns/1ps
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_sweeper_if.slave  bus
);
    // state    | meaning
    // S_IDLE   | waiting for start after reset
    // S_DRIVE  | vector idx driven, settle counter running
    // S_SAMPLE | capture F into table_out[idx], advance or finish
    // S_DONE   | table complete, outputs held until next start
    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] table_q, table_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

`ifdef TRUTH_TABLE_COMPARE_EN
    logic        match_q, match_d;
`else
    logic        unused_expected;
    assign unused_expected = ^bus.expected;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef TRUTH_TABLE_COMPARE_EN
        match_d = match_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_DRIVE;
                    idx_d   = 4'd0;
                    cnt_d   = SETTLE_LOAD;
                    table_d = 16'h0000;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
`ifdef TRUTH_TABLE_COMPARE_EN
                    match_d = 1'b0;
`endif
                end
            end
            S_DRIVE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                table_d[idx_q] = bus.F;
                if (idx_q != 4'd15) begin
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_DRIVE;
                end else begin
                    // idx stays at 15 so the held vector in DONE is 4'b1111
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`ifdef TRUTH_TABLE_COMPARE_EN
                    match_d = (table_d == bus.expected);
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 8'd0;
            table_q <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            table_q <= table_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef TRUTH_TABLE_COMPARE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end
    assign bus.match = match_q;
`else
    assign bus.match = 1'b0;
`endif

    // Vector outputs come straight from the idx flop, so they are glitch-free.
    assign {bus.A, bus.B, bus.C, bus.D} = idx_q;
    assign bus.table_out = table_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: two instances (settle 1 and settle 3).
`timescale 1ns/1ps
module tb_truth_table_sweeper;
    typedef struct {
        logic [15:0] tbl;
        logic        m;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   acc0 = 0;
    int   acc1 = 0;
    logic d0p = 1'b0;
    logic d1p = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    int          kind0 = 0;
    int          kind1 = 2;
    logic [15:0] lut0 = 16'h0000;
    logic [15:0] lut1 = 16'h0000;

    truth_table_sweeper_if ifc0 ();
    truth_table_sweeper_if ifc1 ();

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
    truth_table_sweeper #(.SETTLE_CYCLES(3)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Functions under test, indexed by kind: 0 = A&B, 1 = parity, 2 = D, else lookup table.
    function automatic logic fval(input int kind, input logic [15:0] lut, input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        case (kind)
            0:       return a & b;
            1:       return a ^ b ^ c ^ d;
            2:       return d;
            default: return lut[v];
        endcase
    endfunction

    assign ifc0.F = fval(kind0, lut0, {ifc0.A, ifc0.B, ifc0.C, ifc0.D});
    assign ifc1.F = fval(kind1, lut1, {ifc1.A, ifc1.B, ifc1.C, ifc1.D});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic start_sweep(input int which, input logic [15:0] exp_in);
        exp_t        e;
        logic [15:0] t;
        for (int i = 0; i < 16; i++)
            t[i] = (which == 0) ? fval(kind0, lut0, 4'(i)) : fval(kind1, lut1, 4'(i));
        e.tbl = t;
`ifdef TRUTH_TABLE_COMPARE_EN
        e.m = (t == exp_in);
`else
        e.m = 1'b0;
`endif
        e.lat = (which == 0) ? 16 * 2 : 16 * 4;
        @(negedge clk);
        if (which == 0) begin
            ifc0.expected = exp_in;
            ifc0.start = 1'b1;
            q0.push_back(e);
        end else begin
            ifc1.expected = exp_in;
            ifc1.start = 1'b1;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
        if (which == 0) begin
            acc0 = cyc;
            ifc0.start = 1'b0;
            chk("accept_busy0", ifc0.busy, 1);
            chk("accept_done0", ifc0.done, 0);
            chk("accept_table0", ifc0.table_out, 0);
        end else begin
            acc1 = cyc;
            ifc1.start = 1'b0;
            chk("accept_busy1", ifc1.busy, 1);
            chk("accept_done1", ifc1.done, 0);
            chk("accept_table1", ifc1.table_out, 0);
        end
    endtask

    task automatic wait_drain(input int which);
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            #1;
            if ((which == 0 ? q0.size() : q1.size()) == 0) break;
        end
        if (which == 0) begin
            chk("drain0", q0.size(), 0);
            q0.delete();
        end else begin
            chk("drain1", q1.size(), 0);
            q1.delete();
        end
    endtask

    always @(negedge clk) begin : mon0
        exp_t e;
        if (rst) begin
            d0p = 1'b0;
        end else begin
            if (ifc0.done && !d0p) begin
                if (q0.size() == 0) begin
                    chk("dut0_unexpected_done", 1, 0);
                end else begin
                    e = q0.pop_front();
                    chk("dut0_table", ifc0.table_out, e.tbl);
                    chk("dut0_match", ifc0.match, e.m);
                    chk("dut0_latency", cyc - acc0, e.lat);
                    chk("dut0_busy_low", ifc0.busy, 0);
                    chk("dut0_vec_hold", {ifc0.A, ifc0.B, ifc0.C, ifc0.D}, 4'hF);
                end
            end
            d0p = ifc0.done;
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst) begin
            d1p = 1'b0;
        end else begin
            if (ifc1.done && !d1p) begin
                if (q1.size() == 0) begin
                    chk("dut1_unexpected_done", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("dut1_table", ifc1.table_out, e.tbl);
                    chk("dut1_match", ifc1.match, e.m);
                    chk("dut1_latency", cyc - acc1, e.lat);
                    chk("dut1_busy_low", ifc1.busy, 0);
                    chk("dut1_vec_hold", {ifc1.A, ifc1.B, ifc1.C, ifc1.D}, 4'hF);
                end
            end
            d1p = ifc1.done;
        end
    end

    initial begin
        logic [15:0] ex;
        bit          found;
        ifc0.start = 1'b0;
        ifc1.start = 1'b0;
        ifc0.expected = 16'h0000;
        ifc1.expected = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs0", {ifc0.A, ifc0.B, ifc0.C, ifc0.D, ifc0.table_out,
                            ifc0.busy, ifc0.done, ifc0.match}, 0);
        chk("reset_outs1", {ifc1.A, ifc1.B, ifc1.C, ifc1.D, ifc1.table_out,
                            ifc1.busy, ifc1.done, ifc1.match}, 0);
        @(negedge clk);
        rst = 1'b0;

        // A & B -> F000
        kind0 = 0;
        start_sweep(0, 16'hF000);
        wait_drain(0);

        // Parity against matching and mismatching golden tables
        kind0 = 1;
        start_sweep(0, 16'h6996);
        wait_drain(0);
        start_sweep(0, 16'h6997);
        wait_drain(0);

        // Second start at vector 5 must be ignored (latency still 32)
        start_sweep(0, 16'h6996);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if ({ifc0.A, ifc0.B, ifc0.C, ifc0.D} == 4'd5) found = 1'b1;
        end
        chk("reach_vec5", found, 1);
        ifc0.start = 1'b1;
        @(posedge clk);
        #1;
        ifc0.start = 1'b0;
        chk("ignored_start_busy", ifc0.busy, 1);
        chk("ignored_start_vec_nonzero", ({ifc0.A, ifc0.B, ifc0.C, ifc0.D} >= 4'd5), 1);
        wait_drain(0);

        // Reset at vector 9 discards the sweep
        kind0 = 3;
        lut0 = 16'($urandom);
        start_sweep(0, lut0);
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if ({ifc0.A, ifc0.B, ifc0.C, ifc0.D} == 4'd9) found = 1'b1;
        end
        chk("reach_vec9", found, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_outs", {ifc0.A, ifc0.B, ifc0.C, ifc0.D, ifc0.table_out,
                            ifc0.busy, ifc0.done, ifc0.match}, 0);
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_idle", {ifc0.A, ifc0.B, ifc0.C, ifc0.D, ifc0.table_out,
                             ifc0.busy, ifc0.done, ifc0.match}, 0);
        start_sweep(0, lut0);
        wait_drain(0);

        // Settle 3, F = D -> AAAA after 64 cycles, then restart from DONE
        kind1 = 2;
        start_sweep(1, 16'hAAAA);
        wait_drain(1);
        kind1 = 3;
        lut1 = 16'($urandom);
        start_sweep(1, lut1 ^ 16'h0100);
        wait_drain(1);

        // Random functions with golden tables that sometimes differ in one bit
        for (int r = 0; r < 6; r++) begin
            lut0 = 16'($urandom);
            ex = lut0;
            if ($urandom_range(0, 1) == 1) ex[$urandom_range(0, 15)] ^= 1'b1;
            start_sweep(0, ex);
            wait_drain(0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
